// File: rtl/hc_pkg.sv
// ============================================================================
// Package  : hc_pkg
// Brief    : Shared types and constants for the buffer responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hc_pkg;

  localparam int HC_DATA_WIDTH = 512;
  localparam int HC_WQ_DEPTH   = 8;

  typedef logic [15:0]              t_request_size;
  typedef logic [HC_DATA_WIDTH-1:0] t_buffer_data;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_DONE   = 2'd2
  } t_rd_state;

endpackage

`default_nettype wire

// File: rtl/hc_responder_wq.sv
// ============================================================================
// Module   : hc_responder_wq
// Brief    : Write ingress FIFO with occupancy count and registered almost-full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc_responder_wq
  import hc_pkg::*;
#(
  parameter int DEPTH = HC_WQ_DEPTH,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop_en,
  output logic             o_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_almost_full
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_afull = c_cnt_w'(DEPTH - 2);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_almost_full;
  logic [c_cnt_w-1:0] w_count_next;
  logic               w_push_ok;

  // Pop looks only at the registered count, so a beat pushed into an empty
  // queue becomes visible to the drain one cycle later.
  assign o_pop         = i_pop_en && (r_count != '0);
  assign w_push_ok     = i_push && (r_count != c_full);
  assign o_head        = r_mem[r_rd_ptr];
  assign o_almost_full = r_almost_full;

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !o_pop) begin
      w_count_next = r_count + c_cnt_w'(1);
    end else if (!w_push_ok && o_pop) begin
      w_count_next = r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (o_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count       <= w_count_next;
      r_almost_full <= (w_count_next >= c_afull);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(i_push && (r_count == c_full)));

endmodule

`default_nettype wire

// File: rtl/hc_buffer_responder.sv
// ============================================================================
// Module   : hc_buffer_responder
// Brief    : Multi-buffer line store with streaming reads and queued writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc_buffer_responder
  import hc_pkg::*;
#(
  parameter int  DATA_WIDTH  = HC_DATA_WIDTH,
  parameter int  DEPTH       = 512,
  parameter int  NUM_BUFFERS = 2,
  parameter int  WQ_DEPTH    = HC_WQ_DEPTH,
  localparam int ID_W        = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req_valid,
  input  logic [ID_W-1:0]       rd_req_buffer,
  input  t_request_size         rd_req_size,
  output logic                  rd_req_ready,
  output logic                  rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  rd_done,
  input  logic                  wr_valid,
  input  logic [ID_W-1:0]       wr_buffer,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  input  logic                  drain_en,
  output logic [31:0]           wr_lines
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_lines  = (1 << ID_W) * DEPTH;
  localparam int c_q_w    = ID_W + DATA_WIDTH;

  t_rd_state                  r_state;
  logic [ID_W-1:0]            r_rd_id;
  t_request_size              r_rd_cnt;
  t_request_size              r_rd_last;
  logic                       r_rsp_valid;
  logic                       r_done;
  logic [DATA_WIDTH-1:0]      r_rd_data;
  logic [DATA_WIDTH-1:0]      r_mem [c_lines];
  logic [c_addr_w-1:0]        r_wptr [NUM_BUFFERS];
  logic [31:0]                r_wr_lines;

  logic [ID_W+c_addr_w-1:0]   w_rd_addr;
  logic [ID_W+c_addr_w-1:0]   w_wr_addr;
  logic [c_q_w-1:0]           w_head;
  logic [ID_W-1:0]            w_head_id;
  logic [DATA_WIDTH-1:0]      w_head_data;
  logic                       w_commit;

  // Low bits of the beat counter form the line index, giving modulo-DEPTH wrap.
  assign w_rd_addr    = {r_rd_id, r_rd_cnt[c_addr_w-1:0]};
  assign w_head_id    = w_head[c_q_w-1 -: ID_W];
  assign w_head_data  = w_head[DATA_WIDTH-1:0];
  assign w_wr_addr    = {w_head_id, r_wptr[w_head_id]};

  assign rd_req_ready = (r_state == RD_IDLE);
  assign rd_rsp_valid = r_rsp_valid;
  assign rd_rsp_data  = r_rd_data;
  assign rd_done      = r_done;
  assign wr_lines     = r_wr_lines;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RD_IDLE;
      r_rd_id     <= '0;
      r_rd_cnt    <= '0;
      r_rd_last   <= '0;
      r_rsp_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        RD_IDLE: begin
          if (rd_req_valid) begin
            r_rd_id   <= rd_req_buffer;
            r_rd_cnt  <= '0;
            r_rd_last <= rd_req_size - t_request_size'(1);
            r_state   <= (rd_req_size == '0) ? RD_DONE : RD_STREAM;
          end
        end
        RD_STREAM: begin
          r_rsp_valid <= 1'b1;
          r_rd_cnt    <= r_rd_cnt + t_request_size'(1);
          if (r_rd_cnt == r_rd_last) begin
            r_done  <= 1'b1;
            r_state <= RD_IDLE;
          end
        end
        RD_DONE: begin
          r_done  <= 1'b1;
          r_state <= RD_IDLE;
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (r_state == RD_STREAM) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  // Non-blocking write alongside the registered read yields old data on collision.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_wr_addr] <= w_head_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        r_wptr[b] <= '0;
      end
      r_wr_lines <= '0;
    end else if (w_commit) begin
      r_wptr[w_head_id] <= r_wptr[w_head_id] + c_addr_w'(1);
      r_wr_lines        <= r_wr_lines + 32'd1;
    end
  end

  hc_responder_wq #(
    .DEPTH (WQ_DEPTH),
    .WIDTH (c_q_w)
  ) u_wq (
    .clk           (clk),
    .reset         (reset),
    .i_push        (wr_valid),
    .i_push_data   ({wr_buffer, wr_data}),
    .i_pop_en      (drain_en),
    .o_pop         (w_commit),
    .o_head        (w_head),
    .o_almost_full (wr_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_hc_buffer_responder.sv
// ============================================================================
// Module   : tb_hc_buffer_responder
// Brief    : Directed and randomized checks against a queue/array reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hc_buffer_responder;
  import hc_pkg::*;

  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int NB  = 2;
  localparam int WQD = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            rd_req_valid;
  logic [0:0]      rd_req_buffer;
  t_request_size   rd_req_size;
  logic            rd_req_ready;
  logic            rd_rsp_valid;
  logic [DW-1:0]   rd_rsp_data;
  logic            rd_done;
  logic            wr_valid;
  logic [0:0]      wr_buffer;
  logic [DW-1:0]   wr_data;
  logic            wr_full;
  logic            drain_en;
  logic [31:0]     wr_lines;

  hc_buffer_responder #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEP),
    .NUM_BUFFERS (NB),
    .WQ_DEPTH    (WQD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_req_valid  (rd_req_valid),
    .rd_req_buffer (rd_req_buffer),
    .rd_req_size   (rd_req_size),
    .rd_req_ready  (rd_req_ready),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data),
    .rd_done       (rd_done),
    .wr_valid      (wr_valid),
    .wr_buffer     (wr_buffer),
    .wr_data       (wr_data),
    .wr_full       (wr_full),
    .drain_en      (drain_en),
    .wr_lines      (wr_lines)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: buffer contents, write pointers, ingress queue, and
  // per-cycle expected read outputs keyed by clock-edge number.
  typedef struct { int id; logic [DW-1:0] data; } wbeat_t;
  wbeat_t        wq[$];
  logic [DW-1:0] m_mem   [NB][DEP];
  bit            m_known [NB][DEP];
  int            m_wptr  [NB];
  int            m_lines   = 0;
  int            cyc       = 0;
  int            m_idle_at = 0;
  bit            m_full    = 0;
  bit            e_valid [int];
  logic [DW-1:0] e_data  [int];
  bit            e_dk    [int];
  bit            e_done  [int];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wq.delete();
      m_lines   = 0;
      m_full    = 0;
      m_idle_at = 0;
      foreach (m_wptr[b]) m_wptr[b] = 0;
      e_valid.delete();
      e_data.delete();
      e_dk.delete();
      e_done.delete();
    end else begin
      int pre;
      cyc++;
      pre = wq.size();
      if (rd_req_valid && cyc >= m_idle_at) begin
        int s;
        int id;
        s  = int'(rd_req_size);
        id = int'(rd_req_buffer);
        for (int k = 0; k < s; k++) begin
          e_valid[cyc+1+k] = 1'b1;
          e_data[cyc+1+k]  = m_mem[id][k % DEP];
          e_dk[cyc+1+k]    = m_known[id][k % DEP];
        end
        e_done[(s == 0) ? cyc + 1 : cyc + s] = 1'b1;
        m_idle_at = cyc + ((s == 0) ? 1 : s) + 1;
      end
      if (drain_en && pre > 0) begin
        wbeat_t h;
        h = wq.pop_front();
        m_mem[h.id][m_wptr[h.id]]   = h.data;
        m_known[h.id][m_wptr[h.id]] = 1'b1;
        m_wptr[h.id] = (m_wptr[h.id] + 1) % DEP;
        m_lines++;
      end
      if (wr_valid && pre < WQD) begin
        wbeat_t w;
        w.id   = int'(wr_buffer);
        w.data = wr_data;
        wq.push_back(w);
      end
      m_full = (wq.size() >= WQD - 2);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit ev;
    ev = e_valid.exists(cyc);
    chk("rsp_valid", 64'(rd_rsp_valid), 64'(ev));
    chk("rd_done", 64'(rd_done), 64'(e_done.exists(cyc)));
    chk("req_ready", 64'(rd_req_ready), 64'(cyc + 1 >= m_idle_at));
    chk("wr_full", 64'(wr_full), 64'(m_full));
    chk("wr_lines", 64'(wr_lines), 64'(m_lines));
    if (ev && e_dk[cyc]) chk("rsp_data", 64'(rd_rsp_data), 64'(e_data[cyc]));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    reset = 1'b0; rd_req_valid = 1'b0; rd_req_buffer = '0; rd_req_size = '0;
    wr_valid = 1'b0; wr_buffer = '0; wr_data = '0; drain_en = 1'b0;
    repeat (2) step();
    chk("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    chk("rst_rd_done", 64'(rd_done), 64'd0);
    chk("rst_rsp_data", 64'(rd_rsp_data), 64'd0);
    chk("rst_wr_full", 64'(wr_full), 64'd0);
    chk("rst_wr_lines", 64'(wr_lines), 64'd0);
    chk("rst_ready", 64'(rd_req_ready), 64'd1);
    reset = 1'b1;
    step();

    // Write-then-read: four lines into buffer 1, then stream them back.
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_buffer = 1'b1; wr_data = DW'(32'hA0 + i);
      step();
    end
    wr_valid = 1'b0;
    repeat (3) step();
    chk("wtr_lines", 64'(wr_lines), 64'd4);
    rd_req_valid = 1'b1; rd_req_buffer = 1'b1; rd_req_size = 16'd4;
    step();
    rd_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wtr_beat", {31'd0, rd_rsp_valid, rd_rsp_data}, {31'd0, 1'b1, DW'(32'hA0 + k)});
      chk("wtr_done", 64'(rd_done), 64'(k == 3));
    end
    step();
    chk("wtr_after", 64'(rd_rsp_valid), 64'd0);

    // Backpressure: fill with drain off, initiator reacts one cycle late.
    drain_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_buffer = 1'b0; wr_data = DW'(32'hB0 + i);
      step();
      if (i == 4) chk("bp_full_at5", 64'(wr_full), 64'd0);
      if (i == 5) chk("bp_full_at6", 64'(wr_full), 64'd1);
    end
    wr_valid = 1'b0;
    repeat (3) step();
    chk("bp_full_hold", 64'(wr_full), 64'd1);
    chk("bp_no_commit", 64'(wr_lines), 64'd4);
    drain_en = 1'b1;
    wr_valid = 1'b1; wr_buffer = 1'b0; wr_data = DW'(32'hB7);
    step();
    wr_valid = 1'b0;
    for (int t = 0; t < 20 && wq.size() != 0; t++) step();
    step();
    chk("bp_drained", 64'(wr_lines), 64'd12);
    chk("bp_full_clear", 64'(wr_full), 64'd0);
    rd_req_valid = 1'b1; rd_req_buffer = 1'b0; rd_req_size = 16'd4;
    step();
    rd_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_order", 64'(rd_rsp_data), 64'(32'hB4 + k));
    end

    // Size zero: done two edges later, no beats, ready again after.
    step();
    rd_req_valid = 1'b1; rd_req_buffer = 1'b1; rd_req_size = 16'd0;
    step();
    rd_req_valid = 1'b0;
    step();
    chk("sz0_done", 64'(rd_done), 64'd1);
    chk("sz0_valid", 64'(rd_rsp_valid), 64'd0);
    step();
    chk("sz0_ready", 64'(rd_req_ready), 64'd1);
    chk("sz0_valid2", 64'(rd_rsp_valid), 64'd0);

    // Wrap: six beats from a four-line buffer.
    rd_req_valid = 1'b1; rd_req_buffer = 1'b1; rd_req_size = 16'd6;
    step();
    rd_req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("wrap_beat", 64'(rd_rsp_data), 64'(32'hA0 + (k % 4)));
    end
    step();

    // Randomized write bursts followed by randomized read requests.
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < int'($urandom_range(8, 20)); c++) begin
        wr_valid  = !wr_full && ($urandom_range(0, 3) != 0);
        wr_buffer = 1'($urandom_range(0, 1));
        wr_data   = DW'($urandom);
        drain_en  = ($urandom_range(0, 2) == 0);
        step();
      end
      wr_valid = 1'b0; drain_en = 1'b1;
      for (int t = 0; t < 20 && wq.size() != 0; t++) step();
      step();
      for (int c = 0; c < 16; c++) begin
        rd_req_valid  = ($urandom_range(0, 2) == 0);
        rd_req_buffer = 1'($urandom_range(0, 1));
        rd_req_size   = t_request_size'($urandom_range(0, 9));
        step();
      end
      rd_req_valid = 1'b0;
      repeat (10) step();
    end

    // Reset in the middle of an eight-beat stream.
    rd_req_valid = 1'b1; rd_req_buffer = 1'b0; rd_req_size = 16'd8;
    step();
    rd_req_valid = 1'b0;
    repeat (3) step();
    chk("mid_pre_valid", 64'(rd_rsp_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_valid", 64'(rd_rsp_valid), 64'd0);
    chk("mid_lines", 64'(wr_lines), 64'd0);
    chk("mid_data", 64'(rd_rsp_data), 64'd0);
    chk("mid_done", 64'(rd_done), 64'd0);
    @(negedge clk);
    step();
    reset = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (rd_done || rd_rsp_valid) seen_done++;
    end
    chk("mid_no_more", 64'(seen_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
